// File: rtl/mc_control_fsm_pkg.sv
// Types, opcode constants and the decode-state next-state helper for the
// multicycle RV32I control unit.
package mc_control_fsm_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_J = 2'd3
    } imm_type_t;

    typedef enum logic [1:0] {
        MR_ALUOUT = 2'd0,
        MR_DATA   = 2'd1,
        MR_ALURES = 2'd2
    } mc_result_t;

    typedef enum logic [1:0] {
        SA_PC    = 2'd0,
        SA_OLDPC = 2'd1,
        SA_REG   = 2'd2
    } src_a_t;

    typedef enum logic [1:0] {
        SB_REG  = 2'd0,
        SB_IMM  = 2'd1,
        SB_FOUR = 2'd2
    } src_b_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } mc_state_t;

    // What the ALU decoder is asked to produce in the current state.
    typedef enum logic [1:0] {
        AC_ADD   = 2'd0,
        AC_SUB   = 2'd1,
        AC_RTYPE = 2'd2,
        AC_ITYPE = 2'd3
    } alu_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    // Successor of S_DECODE; anything unsupported lands in S_TRAP.
    function automatic mc_state_t decode_next(input logic [6:0] op,
                                              input logic [2:0] funct3,
                                              input logic       alu_funct_legal);
        mc_state_t nxt;
        nxt = S_TRAP;
        case (op)
            OP_LOAD, OP_STORE: if (funct3 == F3_WORD) nxt = S_MEMADR;
            OP_R:              if (alu_funct_legal) nxt = S_EXECR;
            OP_I:              if (alu_funct_legal) nxt = S_EXECI;
            OP_BRANCH:         if (funct3 == F3_BEQ) nxt = S_BEQ;
            OP_JAL:            nxt = S_JAL;
            default:           nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle controller (master) and the
// datapath (slave): instruction fields and status in, enables and selects out.
interface mc_control_fsm_if;
    import mc_control_fsm_pkg::*;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    mc_result_t result_src;
    src_a_t     alu_src_a;
    src_b_t     alu_src_b;
    alu_op_t    alu_control;
    imm_type_t  imm_src;
    logic       reg_write;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_control, imm_src, reg_write, instr_done, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_control, imm_src, reg_write, instr_done, illegal
    );

endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU operation decode plus funct3 legality for R/I-type ops.
module mc_alu_decoder
    import mc_control_fsm_pkg::*;
(
    input  alu_class_t alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_op_t    alu_control,
    output logic       funct_legal
);

    // Map the requested class and funct bits onto an ALU operation.
    always_comb begin
        funct_legal = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                      (funct3 == 3'b110) || (funct3 == 3'b111);
        alu_control = ALU_ADD;
        unique case (alu_class)
            AC_ADD: alu_control = ALU_ADD;
            AC_SUB: alu_control = ALU_SUB;
            AC_RTYPE, AC_ITYPE: begin
                case (funct3)
                    // funct7b5 only selects sub for register-register ops
                    3'b000:  alu_control = (alu_class == AC_RTYPE && funct7b5) ? ALU_SUB
                                                                               : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the RV32I subset core: one datapath step per
// cycle, memory stalls via mem_ready, permanent trap on illegal encodings.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter mc_state_t RESET_STATE = S_FETCH
) (
    input logic               clk,
    input logic               rst_n,
    mc_control_fsm_if.master  bus
);

    mc_state_t  state;
    mc_state_t  dec_state;
    alu_class_t alu_class;
    alu_op_t    dec_alu;
    logic       funct_legal;
    logic       pc_write_raw;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       instr_done_raw;

    mc_alu_decoder u_alu_decoder (
        .alu_class   (alu_class),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .alu_control (dec_alu),
        .funct_legal (funct_legal)
    );

    // State register and next-state sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            unique case (state)
                S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
                S_DECODE:   state <= decode_next(bus.op, bus.funct3, funct_legal);
                S_MEMADR:   state <= (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BEQ:      state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_TRAP;
            endcase
        end
    end

    // Output decode; during reset the reset state's selects show and all
    // enables are held low regardless of the registered state.
    always_comb begin
        dec_state      = rst_n ? state : RESET_STATE;
        pc_write_raw   = 1'b0;
        ir_write_raw   = 1'b0;
        mem_write_raw  = 1'b0;
        reg_write_raw  = 1'b0;
        instr_done_raw = 1'b0;
        alu_class      = AC_ADD;
        bus.adr_src    = 1'b0;
        bus.result_src = MR_ALUOUT;
        bus.alu_src_a  = SA_PC;
        bus.alu_src_b  = SB_REG;
        bus.imm_src    = IMM_I;
        bus.illegal    = 1'b0;
        unique case (dec_state)
            S_FETCH: begin
                bus.alu_src_b  = SB_FOUR;
                bus.result_src = MR_ALURES;
                ir_write_raw   = bus.mem_ready;
                pc_write_raw   = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a = SA_OLDPC;
                bus.alu_src_b = SB_IMM;
                bus.imm_src   = IMM_B;
            end
            S_MEMADR: begin
                bus.alu_src_a = SA_REG;
                bus.alu_src_b = SB_IMM;
                bus.imm_src   = (bus.op == OP_LOAD) ? IMM_I : IMM_S;
            end
            S_MEMREAD: begin
                bus.adr_src = 1'b1;
            end
            S_MEMWB: begin
                bus.result_src = MR_DATA;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src    = 1'b1;
                mem_write_raw  = 1'b1;
                instr_done_raw = bus.mem_ready;
            end
            S_EXECR: begin
                bus.alu_src_a = SA_REG;
                alu_class     = AC_RTYPE;
            end
            S_EXECI: begin
                bus.alu_src_a = SA_REG;
                bus.alu_src_b = SB_IMM;
                alu_class     = AC_ITYPE;
            end
            S_ALUWB: begin
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_BEQ: begin
                bus.alu_src_a  = SA_REG;
                alu_class      = AC_SUB;
                pc_write_raw   = bus.zero;
                instr_done_raw = 1'b1;
            end
            S_JAL: begin
                bus.alu_src_a = SA_OLDPC;
                bus.alu_src_b = SB_FOUR;
                pc_write_raw  = 1'b1;
            end
            S_TRAP: begin
                bus.illegal = 1'b1;
            end
            default: begin
                bus.illegal = 1'b0;
            end
        endcase
        bus.pc_write   = rst_n & pc_write_raw;
        bus.ir_write   = rst_n & ir_write_raw;
        bus.mem_write  = rst_n & mem_write_raw;
        bus.reg_write  = rst_n & reg_write_raw;
        bus.instr_done = rst_n & instr_done_raw;
    end

    assign bus.alu_control = dec_alu;

endmodule
